lookup_align_stage: RTL and testbench
=====================================

# lookup_align_stage

Read stage of the hash-table lookup pipeline. It accepts lookup keys over a valid/ready handshake and computes the bucket address with an XOR-fold hash. It issues the synchronous memory read and carries the key through a `siso_register` delay line matched to the memory latency. It then compares the returned entry against the delayed key and presents hit/miss plus value to the downstream result stage.

## Interface
- `KEY_WIDTH`, 32: lookup key width.
- `VALUE_WIDTH`, 32: stored value width.
- `ADDR_WIDTH`, 10: bucket address width; table holds 2^ADDR_WIDTH entries.
- `MEM_LATENCY`, 2: enabled cycles from `mem_addr` to valid `mem_rdata`; ≥1.
- `HASH_SEED`, 0: XORed into the folded hash, ADDR_WIDTH LSBs used.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  lookup request valid.
- `in_ready`  out  1  stage can accept.
- `in_key`  in  KEY_WIDTH  key to look up.
- `mem_en`  out  1  memory clock enable; the memory advances its pipeline only when high.
- `mem_addr`  out  ADDR_WIDTH  bucket address.
- `mem_rdata`  in  1+KEY_WIDTH+VALUE_WIDTH  entry `{valid, key, value}`, valid at MSB.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_hit`  out  1  entry valid and key equal.
- `out_key`  out  KEY_WIDTH  looked-up key.
- `out_value`  out  VALUE_WIDTH  stored value on hit, 0 on miss.
- `out_addr`  out  ADDR_WIDTH  bucket address of this lookup.

## Operation
- `advance = !out_valid || out_ready`. This is a global stall.
- `in_ready = advance`, `mem_en = advance`. Every pipeline register, the delay line `write_en`, and the memory move only when `advance` is high.
- Accept: `in_valid && in_ready`. `mem_addr` is driven combinationally from `in_key`.
- Hash: zero-pad the key to a multiple of ADDR_WIDTH, split it into ADDR_WIDTH chunks, XOR all chunks, then XOR `HASH_SEED[ADDR_WIDTH-1:0]`.
- Delay line: `siso_register` with DATA_WIDTH = 1+KEY_WIDTH+ADDR_WIDTH and DELAY = MEM_LATENCY. It carries `{accept, key, addr}`. A bubble (no accept while advancing) inserts valid=0.
- Compare stage, registered, loaded when `advance`:
  - `out_valid` = delayed valid.
  - `out_hit` = delayed valid & entry valid & (entry key == delayed key).
  - `out_value` = hit ? entry value : 0.
  - `out_key`, `out_addr` = delayed fields.
  - When the delayed valid is 0, `out_hit` = 0 and `out_value` = 0.
- `mem_rdata` is sampled only in the cycle its delayed valid reaches the compare stage.
- No reordering and no dropping. Each accepted key yields exactly one result.

## Timing
- Unstalled latency: an accept at cycle t gives `out_valid` at t+MEM_LATENCY+1. Throughput is one lookup per cycle.
- Stall (`out_valid && !out_ready`): all outputs hold stable, `in_ready` = 0, `mem_en` = 0. The memory is required to hold `mem_rdata` while `mem_en` is low.
- Back-to-back with `out_ready` = 1 constantly: no bubbles.
- Reset values: `out_valid`, `out_hit`, `out_key`, `out_value`, `out_addr` = 0. Delay line cleared. `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight lookups are discarded. No result is emitted for them. Stale `mem_rdata` is ignored because the delayed valids are 0.
- Reset has priority over `advance`.

## Structure
- `hash_pkg`:
  - `entry_t` packed struct `{valid, key, value}`.
  - `fold_hash(key, seed)` function.
  - Default width constants, shared with the insert stage and the table memory.
- Sub-module: `siso_register`, one instance, for the key/address/valid delay line.
- The compare and output registers stay in this module.

## Test plan
- Single hit: table[0x006] = {1, 0x00000006, 0xDEADBEEF}; key 0x00000006 at t0 → at t0+3: `out_valid` = 1, `out_hit` = 1, `out_value` = 0xDEADBEEF, `out_addr` = 0x006.
- Collision miss: same table; key 0x00000C05 (folds to 0x006) → `out_hit` = 0, `out_value` = 0, `out_addr` = 0x006.
- Empty entry: table[0x007] has valid = 0 with key field 0x00000406; key 0x00000406 → `out_hit` = 0.
- Streaming with backpressure: 8 consecutive keys; `out_ready` low for 3 cycles mid-stream → 8 results in order, outputs stable during the stall, `in_ready` = 0 exactly while stalled.
- Reset mid-flight: accept 2 keys, assert `reset` one cycle later → no `out_valid` for either key. A new key after reset returns its correct result at +3.
- Seed: HASH_SEED = 0x3FF, key 0x00000006 → `mem_addr` = 0x3F9.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared definitions for the hash-table lookup path.
// Contents:
//   - Default widths shared by the insert stage, the lookup stage and the table memory.
//   - entry_t: one table entry, {valid, key, value}, with valid at the MSB.
//   - fold_hash(): XOR-fold hash of a key down to an address, plus a seed.
package hash_pkg;

    localparam int unsigned HASH_KEY_WIDTH   = 32;
    localparam int unsigned HASH_VALUE_WIDTH = 32;
    localparam int unsigned HASH_ADDR_WIDTH  = 10;

    // Widest key and address that fold_hash can handle. Callers zero-extend
    // into these widths and truncate the result back to their own address width.
    localparam int unsigned HASH_MAX_KW = 256;
    localparam int unsigned HASH_MAX_AW = 32;

    typedef struct packed {
        logic                        valid;
        logic [HASH_KEY_WIDTH-1:0]   key;
        logic [HASH_VALUE_WIDTH-1:0] value;
    } entry_t;

    // Key bit i lands in address bit (i mod addr_w). This is the same as
    // zero-padding the key to a multiple of addr_w and XORing all chunks.
    // Bits of the result at or above addr_w stay equal to the seed bits there,
    // so callers pass a seed that is already masked to addr_w bits.
    function automatic logic [HASH_MAX_AW-1:0] fold_hash(
        input logic [HASH_MAX_KW-1:0] key,
        input logic [HASH_MAX_AW-1:0] seed,
        input int unsigned            addr_w
    );
        logic [HASH_MAX_AW-1:0] h;
        logic [4:0]             idx;
        h = seed;
        for (int unsigned i = 0; i < HASH_MAX_KW; i++) begin
            idx    = 5'(i % addr_w);
            h[idx] = h[idx] ^ key[i];
        end
        return h;
    endfunction

endpackage

// File: rtl/siso_register.sv
// Serial-in serial-out delay line of DELAY stages. It shifts only when
// write_en is high and clears synchronously on reset.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   write_en                shift enable
//   data_in  [DATA_WIDTH]   word entering stage 0
//   data_out [DATA_WIDTH]   word leaving the last stage
module siso_register #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DELAY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] pipe_q [DELAY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                pipe_q[i] <= '0;
            end
        end else if (write_en) begin
            pipe_q[0] <= data_in;
            for (int i = 1; i < int'(DELAY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_out = pipe_q[DELAY-1];

endmodule

// File: rtl/lookup_align_stage.sv
// Read stage of the hash-table lookup pipeline.
// The stage hashes the incoming key straight onto the memory address and
// issues the read. It carries {accept, key, addr} through a delay line that
// matches the memory latency. It then compares the returned entry with the
// delayed key and registers hit/miss and the value.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_key   lookup request handshake
//   mem_en, mem_addr           memory clock enable and bucket address
//   mem_rdata                  returned entry {valid, key, value}
//   out_valid/out_ready        result handshake
//   out_hit, out_key, out_value, out_addr   result fields
module lookup_align_stage
    import hash_pkg::*;
#(
    parameter int unsigned             KEY_WIDTH   = HASH_KEY_WIDTH,
    parameter int unsigned             VALUE_WIDTH = HASH_VALUE_WIDTH,
    parameter int unsigned             ADDR_WIDTH  = HASH_ADDR_WIDTH,
    parameter int unsigned             MEM_LATENCY = 2,
    parameter logic [HASH_MAX_AW-1:0]  HASH_SEED   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [KEY_WIDTH-1:0]               in_key,
    output logic                               mem_en,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [KEY_WIDTH+VALUE_WIDTH:0]     mem_rdata,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_hit,
    output logic [KEY_WIDTH-1:0]               out_key,
    output logic [VALUE_WIDTH-1:0]             out_value,
    output logic [ADDR_WIDTH-1:0]              out_addr
);

    localparam int unsigned DL_W = 1 + KEY_WIDTH + ADDR_WIDTH;

    logic                   advance;
    logic                   accept;
    logic [DL_W-1:0]        dl_in;
    logic [DL_W-1:0]        dl_out;
    logic                   dly_valid;
    logic [KEY_WIDTH-1:0]   dly_key;
    logic [ADDR_WIDTH-1:0]  dly_addr;
    logic                   ent_valid;
    logic [KEY_WIDTH-1:0]   ent_key;
    logic [VALUE_WIDTH-1:0] ent_value;

    logic                   out_valid_q, out_valid_d;
    logic                   out_hit_q,   out_hit_d;
    logic [KEY_WIDTH-1:0]   out_key_q,   out_key_d;
    logic [VALUE_WIDTH-1:0] out_value_q, out_value_d;
    logic [ADDR_WIDTH-1:0]  out_addr_q,  out_addr_d;

    // One global stall. The memory, the delay line and the output registers
    // all freeze together, so the data and its key stay aligned.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign mem_en   = advance;
    assign accept   = in_valid && advance;

    assign mem_addr = ADDR_WIDTH'(fold_hash(HASH_MAX_KW'(in_key),
                                            HASH_MAX_AW'(HASH_SEED[ADDR_WIDTH-1:0]),
                                            ADDR_WIDTH));

    // Stage boundary: issue -> memory-aligned delay line
    assign dl_in = {accept, in_key, mem_addr};

    siso_register #(
        .DATA_WIDTH (DL_W),
        .DELAY      (MEM_LATENCY)
    ) u_key_delay (
        .clk      (clk),
        .reset    (reset),
        .write_en (advance),
        .data_in  (dl_in),
        .data_out (dl_out)
    );

    assign {dly_valid, dly_key, dly_addr} = dl_out;
    assign {ent_valid, ent_key, ent_value} = mem_rdata;

    // Stage boundary: delay line / memory data -> compare and output registers
    always_comb begin
        out_valid_d = dly_valid;
        out_hit_d   = dly_valid && ent_valid && (ent_key == dly_key);
        out_value_d = out_hit_d ? ent_value : '0;
        out_key_d   = dly_key;
        out_addr_d  = dly_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_key_q   <= '0;
            out_value_q <= '0;
            out_addr_q  <= '0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_key_q   <= out_key_d;
            out_value_q <= out_value_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_key   = out_key_q;
    assign out_value = out_value_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_lookup_align_stage.sv
// Directed testbench for lookup_align_stage, with a two-stage table memory
// model gated by mem_en.
module tb_lookup_align_stage;
    import hash_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_key;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [64:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [31:0] out_key;
    logic [31:0] out_value;
    logic [9:0]  out_addr;

    // Seeded instance, used only to observe the address it hashes to.
    logic        s_in_ready, s_mem_en, s_out_valid, s_out_hit;
    logic [9:0]  s_mem_addr, s_out_addr;
    logic [31:0] s_out_key, s_out_value;

    int n_vec = 0;
    int n_bad = 0;

    entry_t tbl [1024];
    entry_t rd_s1, rd_s2;

    always #5 clk = ~clk;

    lookup_align_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_key(out_key), .out_value(out_value),
        .out_addr(out_addr)
    );

    lookup_align_stage #(.HASH_SEED(32'h3FF)) dut_seed (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_key(in_key), .mem_en(s_mem_en), .mem_addr(s_mem_addr),
        .mem_rdata(mem_rdata), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_hit(s_out_hit), .out_key(s_out_key), .out_value(s_out_value),
        .out_addr(s_out_addr)
    );

    // Table memory: two enabled cycles from address to data, holding while mem_en is low.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            rd_s1 <= tbl[mem_addr];
            rd_s2 <= rd_s1;
        end
    end
    assign mem_rdata = rd_s2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated lookup; checks the address at issue and the result 3 cycles later.
    task automatic lookup_one(input string tag, input logic [31:0] key,
                              input logic [9:0] exp_addr, input logic exp_hit,
                              input logic [31:0] exp_value);
        tick();
        in_valid = 1'b1;
        in_key   = key;
        #1;
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        tick();
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_hit"},   64'(out_hit),   64'(exp_hit));
        chk({tag, "_value"}, 64'(out_value), 64'(exp_value));
        chk({tag, "_key"},   64'(out_key),   64'(key));
        chk({tag, "_addr"},  64'(out_addr),  64'(exp_addr));
    endtask

    initial begin
        logic [31:0] hold_key, hold_value;
        logic [9:0]  hold_addr;
        logic        hold_hit;
        int          sent, recv;
        logic [31:0] ek;
        logic        eh;

        for (int i = 0; i < 1024; i++) tbl[i] = '0;
        tbl[10'h006] = '{valid: 1'b1, key: 32'h0000_0006, value: 32'hDEAD_BEEF};
        tbl[10'h007] = '{valid: 1'b0, key: 32'h0000_0406, value: 32'h1234_5678};
        for (int k = 16; k < 24; k++) begin
            if (k % 2 == 0) tbl[k] = '{valid: 1'b1, key: 32'(k), value: 32'hA000_0000 + 32'(k)};
            else            tbl[k] = '{valid: 1'b1, key: 32'hFFFF_0000, value: 32'h5555_5555};
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_key    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_hit",   64'(out_hit),   64'd0);
        chk("rst_out_key",   64'(out_key),   64'd0);
        chk("rst_out_value", 64'(out_value), 64'd0);
        chk("rst_out_addr",  64'(out_addr),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_mem_en",    64'(mem_en),    64'd1);

        // Seeded hash: key 6 folds to 0x006, XOR 0x3FF gives 0x3F9.
        in_key = 32'h0000_0006;
        #1;
        chk("seed_mem_addr", 64'(s_mem_addr), 64'h3F9);

        lookup_one("hit",       32'h0000_0006, 10'h006, 1'b1, 32'hDEAD_BEEF);
        lookup_one("collision", 32'h0000_0C05, 10'h006, 1'b0, 32'h0);
        lookup_one("empty",     32'h0000_0406, 10'h007, 1'b0, 32'h0);

        // Streaming 8 keys 0x10..0x17, downstream stalls in loop cycles 5..7.
        sent = 0;
        recv = 0;
        hold_key = '0; hold_value = '0; hold_addr = '0; hold_hit = 1'b0;
        tick();
        for (int n = 0; n < 40; n++) begin
            out_ready = !(n >= 5 && n <= 7);
            in_valid  = (sent < 8);
            in_key    = 32'h10 + 32'(sent);
            #1;
            if (n < 16) chk("stream_in_ready", 64'(in_ready), (n >= 5 && n <= 7) ? 64'd0 : 64'd1);
            if (n == 5) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                hold_key = out_key; hold_value = out_value;
                hold_addr = out_addr; hold_hit = out_hit;
            end
            if (n == 6 || n == 7) begin
                chk("stall_valid_hold", 64'(out_valid), 64'd1);
                chk("stall_key_hold",   64'(out_key),   64'(hold_key));
                chk("stall_value_hold", 64'(out_value), 64'(hold_value));
                chk("stall_addr_hold",  64'(out_addr),  64'(hold_addr));
                chk("stall_hit_hold",   64'(out_hit),   64'(hold_hit));
                chk("stall_mem_en",     64'(mem_en),    64'd0);
            end
            if (out_valid && out_ready) begin
                ek = 32'h10 + 32'(recv);
                eh = (recv % 2 == 0);
                chk("stream_key",   64'(out_key),   64'(ek));
                chk("stream_hit",   64'(out_hit),   64'(eh));
                chk("stream_value", 64'(out_value), eh ? 64'(32'hA000_0000 + ek) : 64'd0);
                chk("stream_addr",  64'(out_addr),  64'(ek[9:0]));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            if (recv == 8) break;
            tick();
        end
        chk("stream_count", 64'(recv), 64'd8);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // Reset with two lookups in flight: neither may produce a result.
        tick();
        in_valid = 1'b1;
        in_key   = 32'h0000_0006;
        tick();
        in_key   = 32'h0000_0C05;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int n = 0; n < 5; n++) begin
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        lookup_one("after_rst", 32'h0000_0006, 10'h006, 1'b1, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
